trace_arbiter: RTL and testbench

Round-robin arbiter that shares one trace/log output channel among NREQ pipeline observers (PC, IF, ID, bus, ...). Each requester posts a single-cycle sample pulse. The block buffers one sample per requester and serializes the buffered samples onto a valid/ready output port. That port feeds the simulation file-write monitor or an on-board debug sink. Requesters are never stalled: samples that arrive while their buffer is still occupied are dropped and flagged.

---
 rtl/trace_arbiter_if.sv | 13 +
 rtl/trace_arbiter.sv | 109 ++++++++++
 tb/tb_trace_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_arbiter_if.sv
// rtl/trace_arbiter_if.sv - trace output channel (valid/ready sample stream)
interface trace_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int SRC_W = 2
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [SRC_W-1:0] out_src;

  modport master (output out_valid, output out_data, output out_src, input out_ready);
  modport slave  (input out_valid, input out_data, input out_src, output out_ready);
endinterface

// File: rtl/trace_arbiter.sv
// rtl/trace_arbiter.sv - round-robin trace arbiter, one buffered sample per requester
// Optional saturating drop counter enabled by TRACE_DROP_CNT_EN.
module trace_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int SRC_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  trace_arbiter_if.master       out_if,
  output logic [NREQ-1:0]       overflow,
  input  logic                  clr_overflow
`ifdef TRACE_DROP_CNT_EN
  ,
  output logic [15:0]           drop_cnt
`endif
);

  logic [NREQ-1:0]  pend;
  logic [WIDTH-1:0] buf_data [NREQ];
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             out_free;
  logic [NREQ-1:0]  granted;
  logic [NREQ-1:0]  capture;
  logic [NREQ-1:0]  drop;

  assign out_free = !out_if.out_valid || out_if.out_ready;

  // Winner is the pending requester at the smallest rotated distance from rr_ptr.
  always_comb begin : rr_search
    int best_d;
    int d;
    gnt_any = 1'b0;
    gnt_idx = '0;
    best_d  = NREQ;
    d       = 0;
    for (int i = 0; i < NREQ; i++) begin
      d = i - int'(rr_ptr);
      if (d < 0) d = d + NREQ;
      if (pend[i] && d < best_d) begin
        best_d  = d;
        gnt_idx = SRC_W'(i);
        gnt_any = 1'b1;
      end
    end
  end

  always_comb begin
    granted = '0;
    capture = '0;
    drop    = '0;
    for (int i = 0; i < NREQ; i++) begin
      granted[i] = out_free && gnt_any && (gnt_idx == SRC_W'(i));
      capture[i] = req_valid[i] && (!pend[i] || granted[i]);
      drop[i]    = req_valid[i] && pend[i] && !granted[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend             <= '0;
      rr_ptr           <= '0;
      overflow         <= '0;
      out_if.out_valid <= 1'b0;
      out_if.out_data  <= '0;
      out_if.out_src   <= '0;
      for (int i = 0; i < NREQ; i++) buf_data[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (capture[i]) buf_data[i] <= req_data[i*WIDTH +: WIDTH];
      end
      pend <= capture | (pend & ~granted);
      if (out_free) begin
        if (gnt_any) begin
          out_if.out_valid <= 1'b1;
          out_if.out_data  <= buf_data[gnt_idx];
          out_if.out_src   <= gnt_idx;
          rr_ptr           <= (gnt_idx == SRC_W'(NREQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
        end else begin
          out_if.out_valid <= 1'b0;
        end
      end
      // A drop in the same cycle as a clear keeps its flag set.
      overflow <= clr_overflow ? drop : (overflow | drop);
    end
  end

`ifdef TRACE_DROP_CNT_EN
  logic [16:0] cnt_sum;

  always_comb begin
    cnt_sum = clr_overflow ? 17'd0 : {1'b0, drop_cnt};
    for (int i = 0; i < NREQ; i++) cnt_sum = cnt_sum + 17'(drop[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else begin
      drop_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_trace_arbiter.sv
// tb/tb_trace_arbiter.sv - self-checking bench for trace_arbiter with a reference model
module tb_trace_arbiter;
  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int SRC_W = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       overflow;
  logic                  clr_overflow;
`ifdef TRACE_DROP_CNT_EN
  logic [15:0]           drop_cnt;
`endif

  trace_arbiter_if #(.WIDTH(WIDTH), .SRC_W(SRC_W)) tif ();

  trace_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .SRC_W(SRC_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .out_if       (tif),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef TRACE_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: per-requester one-deep mailbox, one output slot, rotating priority.
  bit              m_pend [NREQ];
  logic [WIDTH-1:0] m_buf [NREQ];
  bit              m_valid;
  logic [WIDTH-1:0] m_data;
  int              m_src;
  int              m_rr;
  logic [NREQ-1:0] m_ov;
  int              m_cnt;

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) begin
      m_pend[i] = 0;
      m_buf[i]  = '0;
    end
    m_valid = 0; m_data = '0; m_src = 0; m_rr = 0; m_ov = '0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit free;
    int g;
    int nd;
    bit np [NREQ];
    logic [NREQ-1:0] dr;
    free = !m_valid || tif.out_ready;
    g = -1;
    if (free) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && m_pend[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
      end
    end
    if (free) begin
      if (g >= 0) begin
        m_valid = 1; m_data = m_buf[g]; m_src = g; m_rr = (g + 1) % NREQ;
      end else begin
        m_valid = 0;
      end
    end
    nd = 0; dr = '0;
    for (int i = 0; i < NREQ; i++) begin
      np[i] = m_pend[i] && (i != g);
      if (req_valid[i]) begin
        if (!m_pend[i] || i == g) begin
          np[i] = 1;
          m_buf[i] = req_data[i*WIDTH +: WIDTH];
        end else begin
          dr[i] = 1'b1;
          nd++;
        end
      end
    end
    for (int i = 0; i < NREQ; i++) m_pend[i] = np[i];
    m_ov  = clr_overflow ? dr : (m_ov | dr);
    m_cnt = (clr_overflow ? 0 : m_cnt) + nd;
    if (m_cnt > 65535) m_cnt = 65535;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    clr_overflow = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (tif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", tif.out_valid); end
    n_checks++;
    if (tif.out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", tif.out_data); end
    n_checks++;
    if (tif.out_src !== '0) begin n_fail++; $display("FAIL reset_src: got %0d want 0", tif.out_src); end
    n_checks++;
    if (overflow !== '0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
`ifdef TRACE_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
`endif
  endtask

  task automatic test_single();
    repeat (3) tick();
    req_valid = 4'b0010;
    req_data[1*WIDTH +: WIDTH] = 32'hDEADBEEF;
    tick();
    req_valid = '0;
    n_checks++;
    if (tif.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got valid %0b want 0", tif.out_valid); end
    tick();
    n_checks++;
    if (tif.out_valid !== 1'b1 || tif.out_data !== 32'hDEADBEEF || tif.out_src !== 2'd1) begin
      n_fail++;
      $display("FAIL single_out: got v=%0b d=%h s=%0d want v=1 d=deadbeef s=1", tif.out_valid, tif.out_data, tif.out_src);
    end
    tick();
    n_checks++;
    if (tif.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_once: got valid %0b want 0", tif.out_valid); end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      req_valid = '1;
      for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = 32'h10 + i;
      tick();
      req_valid = '0;
      tick();
      for (int k = 0; k < NREQ; k++) begin
        n_checks++;
        if (tif.out_valid !== 1'b1 || tif.out_src !== SRC_W'(k) || tif.out_data !== 32'h10 + k) begin
          n_fail++;
          $display("FAIL fair_order rep%0d slot%0d: got v=%0b s=%0d d=%h want v=1 s=%0d d=%h",
                   rep, k, tif.out_valid, tif.out_src, tif.out_data, k, 32'h10 + k);
        end
        tick();
      end
      n_checks++;
      if (tif.out_valid !== 1'b0) begin n_fail++; $display("FAIL fair_idle rep%0d: got valid %0b want 0", rep, tif.out_valid); end
    end
  endtask

  task automatic test_backpressure();
    tif.out_ready = 1'b0;
    req_valid = 4'b0001; req_data[0 +: WIDTH] = 32'h55;
    tick();
    req_valid = '0;
    tick();
    req_valid = 4'b0100; req_data[2*WIDTH +: WIDTH] = 32'hA;
    tick();
    req_data[2*WIDTH +: WIDTH] = 32'hB;
    tick();
    req_valid = '0;
    n_checks++;
    if (overflow !== 4'b0100) begin n_fail++; $display("FAIL bp_overflow: got %b want 0100", overflow); end
`ifdef TRACE_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL bp_drop_cnt: got %0d want 1", drop_cnt); end
`endif
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (tif.out_valid !== 1'b1 || tif.out_data !== 32'h55 || tif.out_src !== 2'd0) begin
        n_fail++;
        $display("FAIL bp_hold: got v=%0b d=%h s=%0d want v=1 d=55 s=0", tif.out_valid, tif.out_data, tif.out_src);
      end
      tick();
    end
    tif.out_ready = 1'b1;
    tick();
    n_checks++;
    if (tif.out_valid !== 1'b1 || tif.out_data !== 32'hA || tif.out_src !== 2'd2) begin
      n_fail++;
      $display("FAIL bp_release: got v=%0b d=%h s=%0d want v=1 d=a s=2", tif.out_valid, tif.out_data, tif.out_src);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (tif.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_b: got v=%0b d=%h want v=0", tif.out_valid, tif.out_data); end
    end
  endtask

  task automatic test_stream();
    tif.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8) ? 4'b0001 : 4'b0000;
      req_data[0 +: WIDTH] = c;
      tick();
      if (c >= 1 && c <= 8) begin
        n_checks++;
        if (tif.out_valid !== 1'b1 || tif.out_data !== WIDTH'(c - 1) || tif.out_src !== 2'd0) begin
          n_fail++;
          $display("FAIL stream_beat%0d: got v=%0b d=%h s=%0d want v=1 d=%0d s=0", c, tif.out_valid, tif.out_data, tif.out_src, c - 1);
        end
      end
    end
    n_checks++;
    if (tif.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end: got valid %0b want 0", tif.out_valid); end
    n_checks++;
    if (overflow[0] !== 1'b0) begin n_fail++; $display("FAIL stream_overflow: got %b want bit0=0", overflow); end
  endtask

  task automatic test_clear_vs_set();
    tif.out_ready = 1'b0;
    req_valid = 4'b0001; req_data[0 +: WIDTH] = 32'h77;
    tick();
    req_valid = '0;
    tick();
    req_valid = 4'b1000; req_data[3*WIDTH +: WIDTH] = 32'h31;
    tick();
    req_data[3*WIDTH +: WIDTH] = 32'h32;
    clr_overflow = 1'b1;
    tick();
    req_valid = '0;
    clr_overflow = 1'b0;
    n_checks++;
    if (overflow !== 4'b1000) begin n_fail++; $display("FAIL clr_set_overflow: got %b want 1000", overflow); end
`ifdef TRACE_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL clr_set_drop_cnt: got %0d want 1", drop_cnt); end
`endif
    tif.out_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      req_valid = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = $urandom;
      tif.out_ready = ($urandom_range(0, 9) < 7);
      clr_overflow = ($urandom_range(0, 19) == 0);
      tick();
      n_checks++;
      if (tif.out_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid c%0d: got %0b want %0b", c, tif.out_valid, m_valid); end
      if (m_valid) begin
        n_checks++;
        if (tif.out_data !== m_data || tif.out_src !== SRC_W'(m_src)) begin
          n_fail++;
          $display("FAIL rand_out c%0d: got d=%h s=%0d want d=%h s=%0d", c, tif.out_data, tif.out_src, m_data, m_src);
        end
      end
      n_checks++;
      if (overflow !== m_ov) begin n_fail++; $display("FAIL rand_overflow c%0d: got %b want %b", c, overflow, m_ov); end
`ifdef TRACE_DROP_CNT_EN
      n_checks++;
      if (drop_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL rand_drop_cnt c%0d: got %0d want %0d", c, drop_cnt, m_cnt); end
`endif
    end
    req_valid = '0;
    clr_overflow = 1'b0;
    tif.out_ready = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_reset_mid();
    tif.out_ready = 1'b0;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = 32'hC0 + i;
    tick();
    req_valid = '0;
    tick();
    n_checks++;
    if (tif.out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got valid %0b want 1", tif.out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tif.out_valid !== 1'b0 || tif.out_data !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: got v=%0b d=%h want v=0 d=0", tif.out_valid, tif.out_data);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tif.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++;
      if (tif.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet cyc%0d: got valid %0b want 0", k, tif.out_valid); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    clr_overflow = 1'b0;
    tif.out_ready = 1'b1;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_stream();
    test_clear_vs_set();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
